qnigma_tcp_snd_wnd_ctl: RTL and testbench
=========================================

// Module: qnigma_tcp_snd_wnd_ctl
// PURPOSE
//   Send-side flow-control controller for one TCP connection. Captures ACK segments and
//   applies the negotiated window scale serially. Tracks SND.UNA/SND.WND and produces the
//   usable send window for the TX scheduler. Runs the zero-window persist timer and requests
//   window probes. Sits between the RX parser (ACK fields) and the TX segment scheduler.
// PARAMETERS
//   PERSIST_TICKS  1000  tick strobes before the first zero-window probe
//   MAX_BACKOFF    6     max left-shift of the persist interval (exponential backoff cap)
// PORTS
//   clk        in   1   clock
//   rst        in   1   synchronous reset, active-high
//   syn_rcvd   in   1   pulse: SYN/SYN-ACK accepted during the 3-way handshake (3WHS)
//   syn_scl    in   4   WS option shift (0 if option absent); values >14 are clamped to 14
//   ack_vld    in   1   pulse: valid ACK segment accepted by RX
//   ack_num    in   32  segment ACK number
//   ack_wnd    in   16  raw (unscaled) window field
//   snd_nxt    in   32  SND.NXT from TX
//   data_pend  in   1   TX has unsent data
//   tick       in   1   persist timebase strobe
//   busy       out  1   scaling in progress
//   snd_una    out  32  SND.UNA
//   wnd        out  32  scaled SND.WND
//   usable     out  32  bytes TX may send now
//   zero_wnd   out  1   wnd==0
//   probe      out  1   1-cycle pulse: send 1-byte window probe
// BEHAVIOUR
//   Reset: all outputs 0, scale=0, FSM=IDLE, pending slot empty, persist counter/backoff 0.
//   syn_rcvd (IDLE only, priority over ack_vld in the same cycle; ack_vld is dropped):
//     scale<=min(syn_scl,14); snd_una<=ack_num; wnd<={16'b0,ack_wnd}.
//     Per RFC 7323 the SYN window is never scaled. Effective next cycle.
//   FSM IDLE->SCALE->COMMIT->IDLE:
//     IDLE: on ack_vld or a pending slot, accept the segment (pending first). Stale check
//       uses signed 32-bit $signed(ack_num-snd_una). If <0, discard: no state change,
//       stay IDLE. Otherwise load sh=ack_wnd and ctr=0, then go to SCALE.
//     SCALE: busy=1; each cycle sh<=sh<<1, ctr++. On ctr==scale go to COMMIT (scale=0
//       gives 1 cycle).
//     COMMIT: snd_una<=ack_num, wnd<=sh, then go to IDLE. Total latency: ack_vld to
//       wnd/snd_una update = scale+2 cycles.
//   ack_vld while not IDLE: stored in a one-entry pending slot. A newer ACK overwrites the
//     older one (latest wins). Never lost silently except by overwrite.
//   Width: raw<<14 fits in 30 bits; the upper bits are zero. Arithmetic is modulo 2^32.
//   usable is registered every cycle: d=snd_una+wnd-snd_nxt (mod 2^32).
//     usable=($signed(d)<0)?0:d. A shrunk window clamps to 0 and never wraps to a large value.
//   zero_wnd=(wnd==0), registered alongside wnd.
//   Persist timer is active when zero_wnd && data_pend:
//     counts tick; on count==PERSIST_TICKS<<backoff, probe pulses for 1 cycle, the count
//       clears, and backoff=min(backoff+1,MAX_BACKOFF).
//     Inactive (wnd>0 or !data_pend): count and backoff clear immediately, no probe.
//   Reset mid-scaling: everything returns to reset values; the pending ACK is discarded.
// TESTING
//   1 syn_rcvd scl=7, ack_num=1000, ack_wnd=100 -> wnd=100, snd_una=1000 next cycle (unscaled).
//   2 After 1: ack_vld ack_num=1500 wnd=0x0200, snd_nxt=1500 -> 9 cycles later wnd=0x10000,
//     usable=0x10000. busy high 7 cycles.
//   3 ACKs at t0,t1,t2 during SCALE (num 2000,2100,2200) -> only 2000 and 2200 commit;
//     final snd_una=2200.
//   4 Stale ack_num=snd_una-1, and wrap case snd_una=0xFFFFFF00 with ack=0x00000010 ->
//     first is ignored, second is accepted.
//   5 wnd=0, data_pend=1, PERSIST_TICKS=4 -> probes after 4,8,16 ticks.
//     Nonzero ACK stops probes and clears backoff.
//   6 snd_nxt beyond snd_una+wnd -> usable=0. syn_rcvd with ack_vld in the same cycle ->
//     only syn applied. syn_scl=15 -> scale=14.

Source files
------------

// File: rtl/qnigma_tcp_snd_wnd_ctl.sv
// Send-window control for one TCP connection: ACK window scaling, SND.UNA/SND.WND, usable window, zero-window persist probes.
// Latency ack_vld->wnd is scale+2 cycles; ACKs arriving while busy park in a one-entry slot where the newest overwrites.
module qnigma_tcp_snd_wnd_ctl #(
  parameter int PERSIST_TICKS = 1000,
  parameter int MAX_BACKOFF   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syn_rcvd,
  input  logic [3:0]  syn_scl,
  input  logic        ack_vld,
  input  logic [31:0] ack_num,
  input  logic [15:0] ack_wnd,
  input  logic [31:0] snd_nxt,
  input  logic        data_pend,
  input  logic        tick,
  output logic        busy,
  output logic [31:0] snd_una,
  output logic [31:0] wnd,
  output logic [31:0] usable,
  output logic        zero_wnd,
  output logic        probe
);

  localparam int BW = (MAX_BACKOFF < 1) ? 1 : $clog2(MAX_BACKOFF + 1);
  localparam logic [BW-1:0] BACKOFF_MAX = BW'(MAX_BACKOFF);
  localparam logic [3:0]    SCALE_MAX   = 4'd14;

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    COMMIT
  } state_t;

  state_t state, state_nxt;

  logic [3:0]  scale;
  logic [3:0]  ctr;
  logic [3:0]  ctr_inc;
  logic [31:0] sh;
  logic [31:0] seg_num;

  logic        pnd_vld;
  logic [31:0] pnd_num;
  logic [15:0] pnd_wnd;

  logic        syn_take;
  logic        pnd_take;
  logic        load;
  logic [31:0] acc_num;
  logic [15:0] acc_wnd;
  logic [31:0] acc_diff;

  logic [31:0] usable_d;

  logic [31:0] persist_cnt;
  logic [31:0] persist_cnt_inc;
  logic [31:0] persist_limit;
  logic [BW-1:0] backoff;
  logic        persist_act;

  assign busy    = (state == SCALE);
  assign ctr_inc = ctr + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pending slot is served before a fresh ACK; a SYN in IDLE pre-empts both.
  always_comb begin
    state_nxt = state;
    syn_take  = 1'b0;
    pnd_take  = 1'b0;
    load      = 1'b0;
    acc_num   = pnd_vld ? pnd_num : ack_num;
    acc_wnd   = pnd_vld ? pnd_wnd : ack_wnd;
    acc_diff  = acc_num - snd_una;
    case (state)
      IDLE: begin
        if (syn_rcvd) begin
          syn_take = 1'b1;
        end else if (pnd_vld || ack_vld) begin
          pnd_take = pnd_vld;
          if (!acc_diff[31]) begin
            load      = 1'b1;
            state_nxt = SCALE;
          end
        end
      end
      SCALE: begin
        if ((scale == 4'd0) || (ctr_inc == scale)) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scale    <= '0;
      ctr      <= '0;
      sh       <= '0;
      seg_num  <= '0;
      snd_una  <= '0;
      wnd      <= '0;
      zero_wnd <= 1'b0;
    end else begin
      if (syn_take) begin
        scale    <= (syn_scl > SCALE_MAX) ? SCALE_MAX : syn_scl;
        snd_una  <= ack_num;
        wnd      <= {16'b0, ack_wnd};
        zero_wnd <= (ack_wnd == 16'd0);
      end
      if (load) begin
        seg_num <= acc_num;
        sh      <= {16'b0, acc_wnd};
        ctr     <= '0;
      end
      if ((state == SCALE) && (scale != 4'd0)) begin
        sh  <= sh << 1;
        ctr <= ctr_inc;
      end
      if (state == COMMIT) begin
        snd_una  <= seg_num;
        wnd      <= sh;
        zero_wnd <= (sh == 32'd0);
      end
    end
  end

  // A fresh ACK arriving while the slot drains refills it in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pnd_vld <= 1'b0;
      pnd_num <= '0;
      pnd_wnd <= '0;
    end else begin
      if (ack_vld && ((state != IDLE) || pnd_take)) begin
        pnd_vld <= 1'b1;
        pnd_num <= ack_num;
        pnd_wnd <= ack_wnd;
      end else if (pnd_take) begin
        pnd_vld <= 1'b0;
      end
    end
  end

  assign usable_d = snd_una + wnd - snd_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      usable <= '0;
    end else begin
      usable <= usable_d[31] ? 32'd0 : usable_d;
    end
  end

  assign persist_act     = zero_wnd && data_pend;
  assign persist_limit   = 32'(PERSIST_TICKS) << backoff;
  assign persist_cnt_inc = persist_cnt + 32'd1;

  always_ff @(posedge clk) begin
    if (rst || !persist_act) begin
      persist_cnt <= '0;
      backoff     <= '0;
      probe       <= 1'b0;
    end else begin
      probe <= 1'b0;
      if (tick) begin
        if (persist_cnt_inc == persist_limit) begin
          probe       <= 1'b1;
          persist_cnt <= '0;
          backoff     <= (backoff == BACKOFF_MAX) ? BACKOFF_MAX : backoff + 1'b1;
        end else begin
          persist_cnt <= persist_cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_qnigma_tcp_snd_wnd_ctl.sv
// Directed bench for qnigma_tcp_snd_wnd_ctl: stimulus queues expected window updates and probe tick counts, a negedge monitor pops and compares.
module tb_qnigma_tcp_snd_wnd_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        syn_rcvd = 1'b0;
  logic [3:0]  syn_scl = 4'd0;
  logic        ack_vld = 1'b0;
  logic [31:0] ack_num = 32'd0;
  logic [15:0] ack_wnd = 16'd0;
  logic [31:0] snd_nxt = 32'd0;
  logic        data_pend = 1'b0;
  logic        tick = 1'b0;
  logic        busy;
  logic [31:0] snd_una;
  logic [31:0] wnd;
  logic [31:0] usable;
  logic        zero_wnd;
  logic        probe;

  qnigma_tcp_snd_wnd_ctl #(
    .PERSIST_TICKS(4),
    .MAX_BACKOFF  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .syn_rcvd (syn_rcvd),
    .syn_scl  (syn_scl),
    .ack_vld  (ack_vld),
    .ack_num  (ack_num),
    .ack_wnd  (ack_wnd),
    .snd_nxt  (snd_nxt),
    .data_pend(data_pend),
    .tick     (tick),
    .busy     (busy),
    .snd_una  (snd_una),
    .wnd      (wnd),
    .usable   (usable),
    .zero_wnd (zero_wnd),
    .probe    (probe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  typedef struct {
    logic [31:0] una;
    logic [31:0] wnd;
    logic        z;
    int          cyc;
  } upd_t;

  upd_t upd_q[$];
  int   probe_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_upd(input logic [31:0] u, input logic [31:0] w, input logic z, input int c);
    upd_t e;
    e.una = u;
    e.wnd = w;
    e.z   = z;
    e.cyc = c;
    upd_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_ack(input logic [31:0] num, input logic [15:0] w);
    ack_num = num;
    ack_wnd = w;
    ack_vld = 1'b1;
    step(1);
    ack_vld = 1'b0;
  endtask

  task automatic send_syn(input logic [3:0] scl, input logic [31:0] num, input logic [15:0] w,
                          input logic with_ack);
    syn_scl  = scl;
    ack_num  = num;
    ack_wnd  = w;
    syn_rcvd = 1'b1;
    ack_vld  = with_ack;
    step(1);
    syn_rcvd = 1'b0;
    ack_vld  = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      tick_cnt++;
      step(1);
      tick = 1'b0;
      step(1);
    end
  endtask

  // Monitor: any change of the window state must match the head of the queue.
  logic [31:0] prev_una = 32'd0;
  logic [31:0] prev_wnd = 32'd0;
  logic        prev_z   = 1'b0;
  upd_t        m_e;
  int          m_p;

  always @(negedge clk) begin
    if (snd_una !== prev_una || wnd !== prev_wnd || zero_wnd !== prev_z) begin
      checks++;
      if (upd_q.size() == 0) begin
        errors++;
        $display("FAIL upd_unexpected: got una=%0h wnd=%0h z=%0b at cyc %0d, nothing expected",
                 snd_una, wnd, zero_wnd, cyc);
      end else begin
        m_e = upd_q.pop_front();
        if ({snd_una, wnd, zero_wnd} !== {m_e.una, m_e.wnd, m_e.z}) begin
          errors++;
          $display("FAIL upd_value: got una=%0h wnd=%0h z=%0b expected una=%0h wnd=%0h z=%0b",
                   snd_una, wnd, zero_wnd, m_e.una, m_e.wnd, m_e.z);
        end
        if (m_e.cyc >= 0) begin
          checks++;
          if (cyc != m_e.cyc) begin
            errors++;
            $display("FAIL upd_latency: una=%0h got cyc %0d expected cyc %0d", m_e.una, cyc, m_e.cyc);
          end
        end
      end
      prev_una = snd_una;
      prev_wnd = wnd;
      prev_z   = zero_wnd;
    end
    if (probe === 1'b1) begin
      checks++;
      if (probe_q.size() == 0) begin
        errors++;
        $display("FAIL probe_unexpected: got probe after %0d ticks, none expected", tick_cnt);
      end else begin
        m_p = probe_q.pop_front();
        if (tick_cnt != m_p) begin
          errors++;
          $display("FAIL probe_tick: got probe after %0d ticks expected %0d", tick_cnt, m_p);
        end
      end
    end
  end

  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int busy_cyc;
    rst = 1'b1;
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_una", snd_una, 0);
    chk("rst_wnd", wnd, 0);
    chk("rst_usable", usable, 0);
    chk("rst_zero_wnd", zero_wnd, 0);
    chk("rst_probe", probe, 0);
    rst = 1'b0;
    step(1);

    // SYN window is taken unscaled.
    snd_nxt = 32'd1000;
    exp_upd(32'd1000, 32'd100, 1'b0, cyc + 1);
    send_syn(4'd7, 32'd1000, 16'd100, 1'b0);
    step(3);
    chk("syn_usable", usable, 32'd100);

    // 0x200 << 7 = 0x10000 after scale+2 cycles.
    snd_nxt = 32'd1500;
    exp_upd(32'd1500, 32'h0001_0000, 1'b0, cyc + 9);
    send_ack(32'd1500, 16'h0200);
    busy_cyc = 0;
    repeat (12) begin
      if (busy === 1'b1) busy_cyc++;
      step(1);
    end
    chk("busy_cycles", 32'(busy_cyc), 32'd7);
    chk("scaled_usable", usable, 32'h0001_0000);

    // Back-to-back ACKs: middle one overwritten in the pending slot.
    exp_upd(32'd2000, 32'd128, 1'b0, cyc + 9);
    exp_upd(32'd2200, 32'd384, 1'b0, cyc + 18);
    send_ack(32'd2000, 16'd1);
    send_ack(32'd2100, 16'd2);
    send_ack(32'd2200, 16'd3);
    step(25);
    chk("latest_wins_una", snd_una, 32'd2200);

    // Stale ACK ignored; ACK across the 2^32 wrap accepted.
    send_ack(32'd2199, 16'd5);
    step(12);
    chk("stale_una", snd_una, 32'd2200);
    chk("stale_wnd", wnd, 32'd384);
    exp_upd(32'hFFFF_FF00, 32'd10, 1'b0, cyc + 1);
    send_syn(4'd7, 32'hFFFF_FF00, 16'd10, 1'b0);
    step(2);
    snd_nxt = 32'h0000_0010;
    exp_upd(32'h0000_0010, 32'd512, 1'b0, cyc + 9);
    send_ack(32'h0000_0010, 16'd4);
    step(12);
    chk("wrap_usable", usable, 32'd512);

    // snd_nxt past the right edge clamps usable to zero.
    snd_nxt = 32'd628;
    step(3);
    chk("shrunk_usable", usable, 32'd0);

    // SYN + ACK in one cycle: only SYN applies; scl 15 clamps to 14.
    exp_upd(32'h0000_5000, 32'd3, 1'b0, cyc + 1);
    send_syn(4'd15, 32'h0000_5000, 16'd3, 1'b1);
    step(20);
    exp_upd(32'h0000_5001, 32'h0000_C000, 1'b0, cyc + 16);
    send_ack(32'h0000_5001, 16'd3);
    step(18);

    // Zero window persist: 4, 8, 16, then capped at 16 ticks.
    data_pend = 1'b1;
    snd_nxt   = 32'h0000_5001;
    exp_upd(32'h0000_5002, 32'd0, 1'b1, cyc + 16);
    send_ack(32'h0000_5002, 16'd0);
    step(18);
    chk("zero_wnd_set", zero_wnd, 1);
    tick_cnt = 0;
    probe_q.push_back(4);
    probe_q.push_back(12);
    probe_q.push_back(28);
    probe_q.push_back(44);
    ticks(46);

    // Open window stops probes and clears backoff.
    exp_upd(32'h0000_5003, 32'd16384, 1'b0, cyc + 16);
    send_ack(32'h0000_5003, 16'd1);
    step(18);
    tick_cnt = 0;
    ticks(10);
    exp_upd(32'h0000_5004, 32'd0, 1'b1, cyc + 16);
    send_ack(32'h0000_5004, 16'd0);
    step(18);
    tick_cnt = 0;
    probe_q.push_back(4);
    ticks(5);

    // Reset mid-scaling with a pending ACK: nothing commits afterwards.
    send_ack(32'h0000_5005, 16'd1);
    send_ack(32'h0000_5006, 16'd1);
    step(2);
    exp_upd(32'd0, 32'd0, 1'b0, cyc + 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(30);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_una", snd_una, 0);

    chk("upd_q_drained", 32'(upd_q.size()), 32'd0);
    chk("probe_q_drained", 32'(probe_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
